// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter.
// Bytes arrive over a VALID/READY push port and wait in a small FIFO.
// A four-state serialiser drains the FIFO LSB first. It chains frames
// back to back: the stop bit of one frame is followed directly by the
// start bit of the next, with no idle cycle in between.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                              CLK,
  input  logic                              RSTN,
  input  logic [7:0]                        DATA,
  input  logic                              VALID,
  output logic                              READY,
  output logic                              UART_TX,
  output logic                              BUSY,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   COUNT
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_t;

  // ---------------------------------------------------------------
  // FIFO state
  // ---------------------------------------------------------------
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  // ---------------------------------------------------------------
  // Serialiser state
  // ---------------------------------------------------------------
  state_t        state_q, state_d;
  logic [BW-1:0] baud_q,  baud_d;
  logic [2:0]    bit_q,   bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q,    tx_d;

  logic push;
  logic pop;
  logic fifo_full;
  logic fifo_nonempty;
  logic baud_done;
  logic [7:0] head_byte;

  assign fifo_full     = (count_q == FULL_COUNT);
  assign fifo_nonempty = (count_q != '0);
  assign baud_done     = (baud_q == BAUD_LAST);
  assign head_byte     = mem_q[rd_ptr_q];

  // READY comes from the registered count only. A pop on the same edge
  // therefore cannot open a slot for a push until the following cycle.
  assign push = VALID && !fifo_full;

  assign READY   = !fifo_full;
  assign UART_TX = tx_q;
  assign BUSY    = (state_q != ST_IDLE) || fifo_nonempty;
  assign COUNT   = count_q;

  // Byte storage: contents need no reset because count_q gates every read
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= DATA;
    end
  end

  // FIFO pointer and occupancy update; pointers wrap at the power-of-2 depth
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO registers
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Serialiser next state: each bit lasts CLKS_PER_BIT cycles, and the
  // baud counter reloads on every bit transition so frames never drift
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tx_d   = 1'b1;
        baud_d = '0;
        bit_d  = '0;
        if (fifo_nonempty) begin
          pop     = 1'b1;
          shift_d = head_byte;
          state_d = ST_START;
          tx_d    = 1'b0;
        end
      end

      ST_START: begin
        if (baud_done) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = ST_DATA;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end

      ST_DATA: begin
        if (baud_done) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            // The shift register always presents the current bit at [0]
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end

      ST_STOP: begin
        if (baud_done) begin
          baud_d = '0;
          if (fifo_nonempty) begin
            // Chain straight into the next start bit
            pop     = 1'b1;
            shift_d = head_byte;
            state_d = ST_START;
            tx_d    = 1'b0;
          end else begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
        baud_d  = '0;
        bit_d   = '0;
      end
    endcase
  end

  // Serialiser registers; the line idles high while reset is held
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo with CLKS_PER_BIT=4 and FIFO_DEPTH=4.
// The stimulus pushes the expected bytes into a scoreboard queue.
// A separate receiver process decodes UART_TX and checks each frame.
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       CLK;
  logic       RSTN;
  logic [7:0] DATA;
  logic       VALID;
  logic       READY;
  logic       UART_TX;
  logic       BUSY;
  logic [2:0] COUNT;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int max_count = 0;
  bit mon_en = 1'b1;
  int frame_no = 0;

  logic [7:0] sb[$];
  int frame_start[$];

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RSTN(RSTN), .DATA(DATA), .VALID(VALID),
    .READY(READY), .UART_TX(UART_TX), .BUSY(BUSY), .COUNT(COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (int'(COUNT) > max_count) max_count = int'(COUNT);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Receiver model: mid-bit sampling on falling clock edges
  initial begin : monitor
    logic [7:0] rx;
    forever begin
      @(negedge CLK);
      if (mon_en && RSTN && UART_TX == 1'b0) begin
        frame_start.push_back(cyc);
        repeat (2) @(negedge CLK);
        chk("start_bit", UART_TX, 1'b0);
        for (int k = 0; k < 8; k++) begin
          repeat (CPB) @(negedge CLK);
          rx[k] = UART_TX;
        end
        repeat (CPB) @(negedge CLK);
        chk("stop_bit", UART_TX, 1'b1);
        @(negedge CLK);
        frame_no++;
        $display("frame %0d: received %02h at cycle %0d", frame_no, rx, frame_start[$]);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: got %02h, expected no frame", rx);
        end else begin
          chk("rx_byte", rx, sb.pop_front());
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // Caller sits just after a falling edge; the push lands on the next rising edge
  task automatic push_byte(input logic [7:0] b);
    VALID = 1'b1;
    DATA  = b;
    sb.push_back(b);
    @(negedge CLK);
    VALID = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (BUSY && n < limit) begin
      @(negedge CLK);
      n++;
    end
    chk("drain_done", BUSY, 1'b0);
  endtask

  logic [7:0] t6_bytes [10];

  initial begin : stimulus
    int n0;
    int low_cnt;

    t6_bytes = '{8'h01, 8'h80, 8'hC3, 8'h7E, 8'h5A, 8'h96, 8'h0F, 8'hF0, 8'h33, 8'hCC};
    RSTN  = 1'b0;
    VALID = 1'b0;
    DATA  = 8'h00;

    // Reset values
    repeat (3) @(negedge CLK);
    chk("rst_tx", UART_TX, 1'b1);
    chk("rst_ready", READY, 1'b1);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_count", COUNT, 3'd0);
    RSTN = 1'b1;

    // 1: single byte, latency and frame length
    @(negedge CLK);
    push_byte(8'hA5);
    chk("t1_count_after_push", COUNT, 3'd1);
    chk("t1_tx_still_idle", UART_TX, 1'b1);
    @(negedge CLK);
    chk("t1_tx_start_low", UART_TX, 1'b0);
    chk("t1_count_popped", COUNT, 3'd0);
    repeat (39) @(negedge CLK);
    chk("t1_busy_in_stop", BUSY, 1'b1);
    @(negedge CLK);
    chk("t1_busy_fell", BUSY, 1'b0);
    chk("t1_tx_idle", UART_TX, 1'b1);

    // 2: three consecutive pushes, back-to-back frames
    @(negedge CLK);
    n0 = frame_start.size();
    VALID = 1'b1; DATA = 8'h00; sb.push_back(8'h00);
    @(negedge CLK);
    chk("t2_count_1", COUNT, 3'd1);
    DATA = 8'hFF; sb.push_back(8'hFF);
    @(negedge CLK);
    chk("t2_count_pop_push", COUNT, 3'd1);
    DATA = 8'h55; sb.push_back(8'h55);
    @(negedge CLK);
    VALID = 1'b0;
    chk("t2_count_peak", COUNT, 3'd2);
    repeat (118) @(negedge CLK);
    chk("t2_busy_last_stop", BUSY, 1'b1);
    @(negedge CLK);
    chk("t2_busy_fell", BUSY, 1'b0);
    chk("t2_gap_1", frame_start[n0+1] - frame_start[n0], 40);
    chk("t2_gap_2", frame_start[n0+2] - frame_start[n0+1], 40);

    // 3: hold VALID with 0x10..0x17; 0x15..0x17 meet a full FIFO
    @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      if (i == 5) begin
        chk("t3_count_full", COUNT, 3'd4);
        chk("t3_ready_low", READY, 1'b0);
      end
      VALID = 1'b1;
      DATA  = 8'h10 + 8'(i);
      if (i < 5) sb.push_back(8'h10 + 8'(i));
      @(negedge CLK);
    end
    VALID = 1'b0;
    chk("t3_count_after_drops", COUNT, 3'd4);

    // 4: VALID on the same edge the stop bit pops a full FIFO
    repeat (33) @(negedge CLK);
    chk("t4_full_before_pop", COUNT, 3'd4);
    VALID = 1'b1;
    DATA  = 8'h20;
    @(negedge CLK);
    chk("t4_ready_after_pop", READY, 1'b1);
    chk("t4_count_after_pop", COUNT, 3'd3);
    DATA = 8'h21;
    sb.push_back(8'h21);
    @(negedge CLK);
    VALID = 1'b0;
    chk("t4_count_refilled", COUNT, 3'd4);
    chk("t4_ready_low_again", READY, 1'b0);
    wait_idle(400);
    chk("t4_count_max", max_count, 4);
    chk("t4_sb_drained", sb.size(), 0);

    // 5: reset during data bit 3 discards the frame and the queued byte
    mon_en = 1'b0;
    @(negedge CLK);
    VALID = 1'b1; DATA = 8'h3C;
    @(negedge CLK);
    DATA = 8'h77;
    @(negedge CLK);
    VALID = 1'b0;
    repeat (17) @(negedge CLK);
    chk("t5_count_before_rst", COUNT, 3'd1);
    chk("t5_busy_before_rst", BUSY, 1'b1);
    RSTN = 1'b0;
    #1;
    chk("t5_rst_tx", UART_TX, 1'b1);
    chk("t5_rst_count", COUNT, 3'd0);
    chk("t5_rst_busy", BUSY, 1'b0);
    chk("t5_rst_ready", READY, 1'b1);
    @(negedge CLK);
    @(negedge CLK);
    RSTN = 1'b1;
    low_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      if (UART_TX == 1'b0) low_cnt++;
    end
    chk("t5_no_frame_after_release", low_cnt, 0);
    chk("t5_busy_after_release", BUSY, 1'b0);
    mon_en = 1'b1;

    // 6: ten bytes in bursts of three walk the pointers around twice
    for (int s = 0; s < 10; s += 3) begin
      @(negedge CLK);
      for (int j = s; j < s + 3 && j < 10; j++) begin
        VALID = 1'b1;
        DATA  = t6_bytes[j];
        sb.push_back(t6_bytes[j]);
        @(negedge CLK);
      end
      VALID = 1'b0;
      wait_idle(300);
    end
    repeat (4) @(negedge CLK);
    chk("t6_sb_drained", sb.size(), 0);
    chk("t6_count_zero", COUNT, 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
